// File: rtl/ssit_update_ctrl.sv
// ssit_update_ctrl
// Collects memory-order-violation pairs (load index, store index) from two
// reporters into a small FIFO. Each pair is issued to the SSIT update port
// with one idle cycle after it, because the SSIT update takes two cycles. The
// block also walks the whole table to clear it, either periodically or when
// asked to.
//
// Ports
//   clock, reset_n              clock; synchronous active-low reset
//   viol{0,1}_v_in              reporter pair valid
//   viol{0,1}_ld/st_index_in    reporter load / store PC index
//   viol{0,1}_rdy_out           reporter may enqueue this cycle
//   clear_req_in                request an immediate full clear
//   ssit_update_v_out           one-cycle update strobe, head pair on index1/2
//   ssit_update_index1/2_out    load / store index of the issued pair
//   ssit_clear_v_out            invalidate the entry at ssit_clear_index_out
//   ssit_clear_index_out        entry being invalidated
//   clear_done_out              high on the last cycle of a clear walk
//   dup_drop_out                an accepted pair was discarded as a duplicate
//
// State table
//   S_IDLE  | may issue the FIFO head, or start a pending clear
//   S_GAP   | second cycle of an SSIT update, nothing issued
//   S_CLEAR | one SSIT entry invalidated per cycle
module ssit_update_ctrl #(
  parameter int IDX_W        = 12,
  parameter int SSIT_SIZE    = 4096,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLEAR_PERIOD = 1000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             viol0_v_in,
  input  logic [IDX_W-1:0] viol0_ld_index_in,
  input  logic [IDX_W-1:0] viol0_st_index_in,
  output logic             viol0_rdy_out,
  input  logic             viol1_v_in,
  input  logic [IDX_W-1:0] viol1_ld_index_in,
  input  logic [IDX_W-1:0] viol1_st_index_in,
  output logic             viol1_rdy_out,
  input  logic             clear_req_in,
  output logic             ssit_update_v_out,
  output logic [IDX_W-1:0] ssit_update_index1_out,
  output logic [IDX_W-1:0] ssit_update_index2_out,
  output logic             ssit_clear_v_out,
  output logic [IDX_W-1:0] ssit_clear_index_out,
  output logic             clear_done_out,
  output logic             dup_drop_out
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CLR_W  = (SSIT_SIZE > 1) ? $clog2(SSIT_SIZE) : 1;
  // Room for the two extra cycles the counter may run past the threshold
  // before CLEAR is entered (GAP -> IDLE -> CLEAR).
  localparam int PER_W  = $clog2(CLEAR_PERIOD) + 2;
  localparam int PAIR_W = 2 * IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_CLEAR} state_t;

  state_t             state, state_nxt;
  logic [PAIR_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, wr_ptr1, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [PAIR_W-1:0]  pair0, pair1, head, last_pair;
  logic               last_v, rr_ptr, clear_pending, dup_drop;
  logic [CLR_W-1:0]   clear_ptr;
  logic [PER_W-1:0]   period_cnt;
  logic               free_ge2, free_eq1, acc0, acc1, dup0, dup1, wr0, wr1;
  logic               issue, clear_last, clear_entry;

  assign pair0 = {viol0_ld_index_in, viol0_st_index_in};
  assign pair1 = {viol1_ld_index_in, viol1_st_index_in};
  assign head  = mem[rd_ptr];

  // Space is judged on the count at cycle start; a same-cycle pop never helps.
  assign free_ge2      = count <= CNT_W'(FIFO_DEPTH - 2);
  assign free_eq1      = count == CNT_W'(FIFO_DEPTH - 1);
  assign viol0_rdy_out = free_ge2 | (free_eq1 & ~rr_ptr);
  assign viol1_rdy_out = free_ge2 | (free_eq1 & rr_ptr);

  assign acc0 = viol0_v_in & viol0_rdy_out;
  assign acc1 = viol1_v_in & viol1_rdy_out;
  // viol1 is compared against whatever viol0 leaves as the last-written pair:
  // if viol0 was accepted that is pair0, whether written or dropped.
  assign dup0 = last_v & (pair0 == last_pair);
  assign dup1 = acc0 ? (pair1 == pair0) : (last_v & (pair1 == last_pair));
  assign wr0  = acc0 & ~dup0;
  assign wr1  = acc1 & ~dup1;
  assign wr_ptr1 = wr_ptr + PTR_W'(wr0);

  assign issue       = (state == S_IDLE) & ~clear_pending & (count != '0);
  assign clear_last  = clear_ptr == CLR_W'(SSIT_SIZE - 1);
  assign clear_entry = (state != S_CLEAR) & (state_nxt == S_CLEAR);

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clear_pending) state_nxt = S_CLEAR;
               else if (count != '0) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      S_CLEAR: if (clear_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ssit_update_v_out      = 1'b0;
    ssit_update_index1_out = '0;
    ssit_update_index2_out = '0;
    ssit_clear_v_out       = 1'b0;
    ssit_clear_index_out   = '0;
    clear_done_out         = 1'b0;
    if (issue) begin
      ssit_update_v_out      = 1'b1;
      ssit_update_index1_out = head[PAIR_W-1:IDX_W];
      ssit_update_index2_out = head[IDX_W-1:0];
    end
    if (state == S_CLEAR) begin
      ssit_clear_v_out     = 1'b1;
      ssit_clear_index_out = IDX_W'(clear_ptr);
      clear_done_out       = clear_last;
    end
  end

  assign dup_drop_out = dup_drop;

  // FIFO storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (wr0) mem[wr_ptr]  <= pair0;
    if (wr1) mem[wr_ptr1] <= pair1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      last_pair     <= '0;
      last_v        <= 1'b0;
      rr_ptr        <= 1'b0;
      dup_drop      <= 1'b0;
      clear_pending <= 1'b0;
      clear_ptr     <= '0;
      period_cnt    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(wr0) + PTR_W'(wr1);
      rd_ptr   <= rd_ptr + PTR_W'(issue);
      count    <= count + CNT_W'(wr0) + CNT_W'(wr1) - CNT_W'(issue);
      dup_drop <= (acc0 & dup0) | (acc1 & dup1);

      if (wr1) begin
        last_pair <= pair1;
        last_v    <= 1'b1;
      end else if (wr0) begin
        last_pair <= pair0;
        last_v    <= 1'b1;
      end

      if (free_eq1 & (acc0 | acc1)) rr_ptr <= ~rr_ptr;

      if (state == S_CLEAR) begin
        if (clear_last) begin
          clear_ptr     <= '0;
          clear_pending <= 1'b0;
        end else begin
          clear_ptr <= clear_ptr + 1'b1;
        end
      end else if (clear_req_in || period_cnt == PER_W'(CLEAR_PERIOD - 1)) begin
        clear_pending <= 1'b1;
      end

      if (clear_entry)            period_cnt <= '0;
      else if (state != S_CLEAR)  period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ssit_update_ctrl.sv
// Bench for ssit_update_ctrl with a small table (8 entries) and a short clear
// period (16 cycles). A queue-based reference model is checked against the DUT
// on every cycle; directed tests also pin key cycles to literal values.
module tb_ssit_update_ctrl;

  localparam int IDX_W  = 12;
  localparam int SSIT_N = 8;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             viol0_v_in, viol1_v_in, clear_req_in;
  logic [IDX_W-1:0] viol0_ld_index_in, viol0_st_index_in;
  logic [IDX_W-1:0] viol1_ld_index_in, viol1_st_index_in;
  logic             viol0_rdy_out, viol1_rdy_out;
  logic             ssit_update_v_out, ssit_clear_v_out, clear_done_out, dup_drop_out;
  logic [IDX_W-1:0] ssit_update_index1_out, ssit_update_index2_out, ssit_clear_index_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  ssit_update_ctrl #(
    .IDX_W(IDX_W), .SSIT_SIZE(SSIT_N), .FIFO_DEPTH(DEPTH), .CLEAR_PERIOD(PERIOD)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .viol0_v_in(viol0_v_in), .viol0_ld_index_in(viol0_ld_index_in),
    .viol0_st_index_in(viol0_st_index_in), .viol0_rdy_out(viol0_rdy_out),
    .viol1_v_in(viol1_v_in), .viol1_ld_index_in(viol1_ld_index_in),
    .viol1_st_index_in(viol1_st_index_in), .viol1_rdy_out(viol1_rdy_out),
    .clear_req_in(clear_req_in),
    .ssit_update_v_out(ssit_update_v_out),
    .ssit_update_index1_out(ssit_update_index1_out),
    .ssit_update_index2_out(ssit_update_index2_out),
    .ssit_clear_v_out(ssit_clear_v_out), .ssit_clear_index_out(ssit_clear_index_out),
    .clear_done_out(clear_done_out), .dup_drop_out(dup_drop_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] mq[$];
  logic [23:0] m_last;
  bit          m_last_ok, m_rr, m_gap, m_pend, m_dup, live;
  int          m_clr, m_per;

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_last_ok = 0; m_rr = 0; m_gap = 0; m_pend = 0; m_dup = 0;
    m_clr = -1; m_per = 0;
  endtask

  task automatic offer(input logic [23:0] p);
    if (m_last_ok && p == m_last) m_dup = 1;
    else begin
      mq.push_back(p);
      m_last = p;
      m_last_ok = 1;
    end
  endtask

  always @(negedge clock) begin : model_cmp
    int free;
    bit e_rdy0, e_rdy1, e_issue, clearing, a0, a1, set_p;
    free     = DEPTH - mq.size();
    e_rdy0   = (free >= 2) || (free == 1 && !m_rr);
    e_rdy1   = (free >= 2) || (free == 1 && m_rr);
    clearing = (m_clr >= 0);
    e_issue  = !clearing && !m_gap && !m_pend && mq.size() > 0;
    if (live) begin
      chk("rdy0", 32'(viol0_rdy_out), 32'(e_rdy0));
      chk("rdy1", 32'(viol1_rdy_out), 32'(e_rdy1));
      chk("update_v", 32'(ssit_update_v_out), 32'(e_issue));
      if (e_issue) begin
        chk("update_index1", 32'(ssit_update_index1_out), 32'(mq[0][23:12]));
        chk("update_index2", 32'(ssit_update_index2_out), 32'(mq[0][11:0]));
      end
      chk("clear_v", 32'(ssit_clear_v_out), 32'(clearing));
      if (clearing) chk("clear_index", 32'(ssit_clear_index_out), 32'(m_clr));
      chk("clear_done", 32'(clear_done_out), 32'(clearing && m_clr == SSIT_N - 1));
      chk("dup_drop", 32'(dup_drop_out), 32'(m_dup));
    end
    if (!reset_n) begin
      model_reset();
      live = 1;
    end else if (live) begin
      a0 = viol0_v_in && e_rdy0;
      a1 = viol1_v_in && e_rdy1;
      if (e_issue) void'(mq.pop_front());
      m_dup = 0;
      if (a0) offer({viol0_ld_index_in, viol0_st_index_in});
      if (a1) offer({viol1_ld_index_in, viol1_st_index_in});
      if (free == 1 && (a0 || a1)) m_rr = !m_rr;
      if (clearing) begin
        if (m_clr == SSIT_N - 1) begin
          m_clr = -1;
          m_pend = 0;
        end else m_clr++;
      end else begin
        set_p = clear_req_in || (m_per == PERIOD - 1);
        if (m_gap) begin
          m_gap = 0;
          m_per++;
        end else if (m_pend) begin
          m_clr = 0;
          m_per = 0;
        end else begin
          if (e_issue) m_gap = 1;
          m_per++;
        end
        if (set_p) m_pend = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
    cyc++;
  endtask

  task automatic drive(input logic v0, input logic [11:0] l0, input logic [11:0] s0,
                       input logic v1, input logic [11:0] l1, input logic [11:0] s1,
                       input logic req);
    viol0_v_in = v0; viol0_ld_index_in = l0; viol0_st_index_in = s0;
    viol1_v_in = v1; viol1_ld_index_in = l1; viol1_st_index_in = s1;
    clear_req_in = req;
  endtask

  task automatic idle();
    drive(0, 12'h0, 12'h0, 0, 12'h0, 12'h0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    live = 0;
    model_reset();

    // Reset state
    do_reset();
    chk("reset_rdy0", 32'(viol0_rdy_out), 32'd1);
    chk("reset_rdy1", 32'(viol1_rdy_out), 32'd1);
    chk("reset_update_v", 32'(ssit_update_v_out), 32'd0);
    chk("reset_clear_v", 32'(ssit_clear_v_out), 32'd0);

    // Single pair: accepted cycle 0, issued cycle 1 only
    drive(1, 12'h012, 12'h345, 0, 12'h0, 12'h0, 0);
    tick();
    idle();
    chk("single_v_c1", 32'(ssit_update_v_out), 32'd1);
    chk("single_i1", 32'(ssit_update_index1_out), 32'h012);
    chk("single_i2", 32'(ssit_update_index2_out), 32'h345);
    tick();
    chk("single_v_c2", 32'(ssit_update_v_out), 32'd0);
    repeat (3) tick();

    // Burst: both ports, distinct pairs, 3 cycles
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (cyc == 1) begin
        chk("burst_rdy0_c1", 32'(viol0_rdy_out), 32'd1);
        chk("burst_rdy1_c1", 32'(viol1_rdy_out), 32'd1);
        chk("burst_i1_c1", 32'(ssit_update_index1_out), 32'h0a0);
      end
      if (cyc == 2) begin
        chk("burst_rdy0_c2", 32'(viol0_rdy_out), 32'd1);
        chk("burst_rdy1_c2", 32'(viol1_rdy_out), 32'd0);
      end
      if (cyc == 3) begin
        chk("burst_rdy0_c3", 32'(viol0_rdy_out), 32'd0);
        chk("burst_i1_c3", 32'(ssit_update_index1_out), 32'h0b0);
      end
      if (cyc == 9) chk("burst_i1_c9", 32'(ssit_update_index1_out), 32'h0a2);
      if (cyc < 3)
        drive(1, 12'(12'h0a0 + cyc), 12'(12'h1a0 + cyc), 1, 12'(12'h0b0 + cyc), 12'(12'h1b0 + cyc), 0);
      else idle();
      tick();
    end

    // Full FIFO while held in CLEAR, then drain with ports kept busy
    do_reset();
    drive(0, 12'h0, 12'h0, 0, 12'h0, 12'h0, 1);
    tick();
    idle();
    tick();
    for (int i = 0; i < 50; i++) begin
      if (cyc == 4) begin
        chk("full_rdy0_c4", 32'(viol0_rdy_out), 32'd0);
        chk("full_rdy1_c4", 32'(viol1_rdy_out), 32'd0);
        chk("full_clear_v_c4", 32'(ssit_clear_v_out), 32'd1);
      end
      if (cyc == 10) begin
        chk("full_rdy0_c10", 32'(viol0_rdy_out), 32'd0);
        chk("full_update_v_c10", 32'(ssit_update_v_out), 32'd1);
        chk("full_i1_c10", 32'(ssit_update_index1_out), 32'h102);
      end
      if (cyc == 11) begin
        chk("full_rdy0_c11", 32'(viol0_rdy_out), 32'd1);
        chk("full_rdy1_c11", 32'(viol1_rdy_out), 32'd0);
      end
      if (cyc == 13) begin
        chk("full_rdy0_c13", 32'(viol0_rdy_out), 32'd0);
        chk("full_rdy1_c13", 32'(viol1_rdy_out), 32'd1);
      end
      if (cyc <= 20)
        drive(1, 12'(12'h100 + cyc), 12'(12'h200 + cyc), 1, 12'(12'h300 + cyc), 12'(12'h400 + cyc), 0);
      else idle();
      tick();
    end

    // Duplicates: consecutive, same-cycle, and against an empty FIFO
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (cyc == 1) chk("dup_v_c1", 32'(ssit_update_v_out), 32'd1);
      if (cyc == 2) chk("dup_drop_c2", 32'(dup_drop_out), 32'd1);
      if (cyc == 3) begin
        chk("dup_v_c3", 32'(ssit_update_v_out), 32'd0);
        chk("dup_drop_c3", 32'(dup_drop_out), 32'd0);
      end
      if (cyc == 5) begin
        chk("dup_pair_i1_c5", 32'(ssit_update_index1_out), 32'h005);
        chk("dup_drop_c5", 32'(dup_drop_out), 32'd1);
      end
      if (cyc == 7) chk("dup_pair_v_c7", 32'(ssit_update_v_out), 32'd0);
      if (cyc == 9) begin
        chk("dup_empty_drop_c9", 32'(dup_drop_out), 32'd1);
        chk("dup_empty_v_c9", 32'(ssit_update_v_out), 32'd0);
      end
      case (cyc)
        0, 1:    drive(1, 12'h001, 12'h002, 0, 12'h0, 12'h0, 0);
        4:       drive(1, 12'h005, 12'h006, 1, 12'h005, 12'h006, 0);
        8:       drive(1, 12'h005, 12'h006, 0, 12'h0, 12'h0, 0);
        default: idle();
      endcase
      tick();
    end

    // Clear request in GAP; pending clear beats a non-empty FIFO
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (cyc == 3) begin
        chk("gapclr_v_c3", 32'(ssit_update_v_out), 32'd0);
        chk("gapclr_clear_c3", 32'(ssit_clear_v_out), 32'd0);
      end
      if (cyc == 4) begin
        chk("gapclr_clear_c4", 32'(ssit_clear_v_out), 32'd1);
        chk("gapclr_idx_c4", 32'(ssit_clear_index_out), 32'd0);
      end
      if (cyc == 11) chk("gapclr_done_c11", 32'(clear_done_out), 32'd1);
      if (cyc == 12) chk("gapclr_i1_c12", 32'(ssit_update_index1_out), 32'h0cc);
      case (cyc)
        0:       drive(1, 12'h0aa, 12'h0bb, 1, 12'h0cc, 12'h0dd, 0);
        2:       drive(0, 12'h0, 12'h0, 0, 12'h0, 12'h0, 1);
        default: idle();
      endcase
      tick();
    end

    // Periodic clear; request during CLEAR is ignored
    do_reset();
    for (int i = 0; i < 52; i++) begin
      if (cyc == 16) chk("per_clear_c16", 32'(ssit_clear_v_out), 32'd0);
      if (cyc == 17) begin
        chk("per_clear_c17", 32'(ssit_clear_v_out), 32'd1);
        chk("per_idx_c17", 32'(ssit_clear_index_out), 32'd0);
      end
      if (cyc == 24) begin
        chk("per_idx_c24", 32'(ssit_clear_index_out), 32'd7);
        chk("per_done_c24", 32'(clear_done_out), 32'd1);
      end
      if (cyc == 26) chk("per_clear_c26", 32'(ssit_clear_v_out), 32'd0);
      if (cyc == 41) chk("per_clear_c41", 32'(ssit_clear_v_out), 32'd0);
      if (cyc == 42) chk("per_clear_c42", 32'(ssit_clear_v_out), 32'd1);
      if (cyc == 20) drive(0, 12'h0, 12'h0, 0, 12'h0, 12'h0, 1);
      else idle();
      tick();
    end

    // Reset in the middle of a clear walk
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (cyc == 20) begin
        chk("rstclr_idx_c20", 32'(ssit_clear_index_out), 32'd3);
        reset_n = 1'b0;
      end else reset_n = 1'b1;
      if (cyc == 21) begin
        chk("rstclr_clear_c21", 32'(ssit_clear_v_out), 32'd0);
        chk("rstclr_rdy0_c21", 32'(viol0_rdy_out), 32'd1);
        chk("rstclr_rdy1_c21", 32'(viol1_rdy_out), 32'd1);
        chk("rstclr_done_c21", 32'(clear_done_out), 32'd0);
      end
      if (cyc == 37) chk("rstclr_clear_c37", 32'(ssit_clear_v_out), 32'd0);
      if (cyc == 38) chk("rstclr_clear_c38", 32'(ssit_clear_v_out), 32'd1);
      idle();
      tick();
    end
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssit_update_ctrl.md
# ssit_update_ctrl

Sequencing controller for the store set ID table (SSIT) in the rename stage. It collects memory-order-violation reports (load/store index pairs) from two reporters, buffers them in a small FIFO, and issues them to the SSIT update port. Issues are spaced to respect the SSIT's two-cycle update. The block also runs the periodic and on-demand full-table clear walk that bounds store-set aliasing.

## Interface
Parameters:
- IDX_W, 12, SSIT index width
- SSIT_SIZE, 4096, entries walked by a clear
- FIFO_DEPTH, 4, violation FIFO entries (power of two, ≥2)
- CLEAR_PERIOD, 1000000, cycles between automatic clears (≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- viol0_v_in  in  1  reporter 0 pair valid
- viol0_ld_index_in  in  IDX_W  reporter 0 load PC index
- viol0_st_index_in  in  IDX_W  reporter 0 store PC index
- viol0_rdy_out  out  1  reporter 0 may enqueue this cycle
- viol1_v_in, viol1_ld_index_in, viol1_st_index_in, viol1_rdy_out  same as reporter 0, for reporter 1
- clear_req_in  in  1  request an immediate full clear
- ssit_update_v_out  out  1  one-cycle update strobe to SSIT
- ssit_update_index1_out  out  IDX_W  load index of issued pair
- ssit_update_index2_out  out  IDX_W  store index of issued pair
- ssit_clear_v_out  out  1  invalidate SSIT entry at clear index
- ssit_clear_index_out  out  IDX_W  entry being invalidated
- clear_done_out  out  1  pulse on last clear cycle
- dup_drop_out  out  1  pulse when an accepted pair was discarded as duplicate

## Operation
- Handshake: a pair is accepted when v_in and rdy_out are both high in the same cycle. rdy_out depends only on registered state, never on v_in.
- free = FIFO_DEPTH − count, taken at cycle start. A same-cycle pop does not add space.
- free ≥ 2: both rdy high. Simultaneous accepts enqueue viol0 first, then viol1.
- free == 1: only the port selected by rr_ptr (reset 0 = viol0) is ready. rr_ptr toggles on every acceptance made with free == 1.
- free == 0: both rdy low.
- Duplicate filter: an accepted pair equal (both indices) to the most recently written FIFO entry is not written, and dup_drop_out pulses next cycle.
  - Also applies while the FIFO is empty, provided the last-written register is valid.
  - If viol0 and viol1 carry identical pairs in one cycle, only viol0 is written.
- FSM states:
  - IDLE: if clear_pending, go to CLEAR with no issue this cycle. Else if FIFO non-empty, drive ssit_update_v_out = 1 with the head pair combinationally, pop at the edge, go to GAP.
  - GAP: no issue; return to IDLE. This covers SSIT stage two.
  - CLEAR: ssit_clear_v_out = 1, ssit_clear_index_out = clear_ptr. clear_ptr increments each cycle. At clear_ptr == SSIT_SIZE−1, pulse clear_done_out, zero clear_ptr and clear_pending, go to IDLE.
- Period counter:
  - Increments every cycle outside CLEAR and zeroes on CLEAR entry.
  - Reaching CLEAR_PERIOD−1 sets clear_pending.
  - clear_req_in also sets clear_pending, except in CLEAR, where it is ignored.
- Violations keep being accepted during CLEAR and GAP. FIFO contents survive a clear.
- Reset values: every output 0 except viol0_rdy_out = viol1_rdy_out = 1. FIFO is emptied; state IDLE; counters, rr_ptr, clear_pending, and last-written valid are all 0.
- Reset asserted mid-update or mid-clear abandons the operation; nothing is replayed.

## Timing
- Pair accepted in cycle t: earliest issue in cycle t+1 (empty FIFO, IDLE).
- Maximum issue rate is one update per 2 cycles. Back-to-back issues are at t and t+2.
- Clear entered from IDLE with clear_pending: CLEAR starts the next cycle and lasts exactly SSIT_SIZE cycles.
- clear_req_in during GAP: CLEAR starts 2 cycles later (GAP→IDLE→CLEAR).
- clear_pending beats a non-empty FIFO in IDLE.

## Test plan
- Single pair: viol0 (0x012,0x345) in cycle 0 → ssit_update_v_out high only in cycle 1 with index1 = 0x012, index2 = 0x345.
- Burst: both ports valid with distinct pairs for 3 cycles →
  - Pairs accepted while free allows, rr alternating at free == 1.
  - Issues at cycles 1, 3, 5, …, in acceptance order, viol0 before viol1 within a cycle.
  - FIFO never exceeds 4.
- Full FIFO: fill 4 entries while held in CLEAR (SSIT_SIZE = 8) → both rdy low. After CLEAR, rdy_out = 0 whenever the FIFO has no free slot at cycle start, and space becomes available 2 cycles apart as entries drain.
- Duplicate: viol0 (0x001,0x002) twice consecutively → one issue only. dup_drop_out pulses once.
- Periodic clear: CLEAR_PERIOD = 16, SSIT_SIZE = 8, idle →
  - clear_v high for 8 cycles with indices 0..7.
  - clear_done_out on index 7.
  - Repeats 16 cycles later.
- Reset mid-clear: reset_n low at clear index 3 → next cycle all outputs 0, rdy = 1. No clear resumes until the period elapses or clear_req_in.
